systolic_output_collector: RTL and testbench
============================================

Name: systolic_output_collector

Overview:
- Downstream stage of the mode-muxed systolic array wrapper.
- Captures the row-serial output_out stream (one Dimension-lane row per beat) into a local Dimension x Dimension buffer.
- Over multiple passes, accumulates partial sums lane-wise (needed for channel tiling in conv and transconv).
- After the final pass, drains the buffer row-by-row to the result BRAM write port with valid/ready backpressure.

Parameters:
- DW, 16, signed lane width (matches array DW)
- Dimension, 16, lanes per row and rows per pass
- ADDR_W, 10, BRAM write address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle job start; sampled only in IDLE
- num_passes  in  8  passes to accumulate; 0 treated as 1; latched on start
- base_addr  in  ADDR_W  BRAM row address of buffer row 0; latched on start
- in_valid  in  1  output_out row valid
- in_ready  out  1  collector accepts a row this cycle
- output_out  in  DW*Dimension  signed row from systolic array; lane k at bits [DW*k +: DW]
- wr_valid  out  1  BRAM write request
- wr_ready  in  1  BRAM side accepts the write
- wr_addr  out  ADDR_W  write address
- wr_data  out  DW*Dimension  row data, same lane packing as output_out
- busy  out  1  high in CAPTURE, DRAIN and DONE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; in_ready, wr_valid, busy, done = 0; wr_addr, wr_data = 0; row and pass counters = 0.
  - Buffer contents are not cleared. This is safe because pass 0 always overwrites.
  - Reset mid-job aborts the job with no further writes.
- IDLE:
  - start=1 latches num_passes and base_addr, then goes to CAPTURE.
  - in_valid is ignored; in_ready=0.
- CAPTURE:
  - in_ready=1 (combinational from state).
  - A beat is accepted when in_valid && in_ready.
  - Accepted beat with pass==0: buf[row] <= output_out.
  - Accepted beat with pass>0: buf[row][k] <= buf[row][k] + lane k, for each lane k.
  - After each beat, row increments. At row==Dimension-1, row wraps to 0 and pass increments.
  - On the beat that completes row Dimension-1 of the last pass, next state is DRAIN. in_ready drops the following cycle.
- DRAIN:
  - wr_valid=1; wr_addr = base_addr + row, modulo 2^ADDR_W (wraps silently); wr_data = buf[row]. All outputs are registered.
  - Outputs hold stable while wr_ready=0.
  - On wr_valid && wr_ready, row increments and the next row's data/address appear on the next cycle.
  - On the handshake of row Dimension-1, go to DONE; wr_valid=0 next cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy falls on the same edge that enters IDLE.
- start asserted while busy is ignored, with no effect on latched values.
- Latency: first wr_valid occurs 1 cycle after the final accepted beat. Minimum job length = num_passes*Dimension + Dimension + 2 cycles.
- Arithmetic: two's-complement add, result truncated to DW (wraps modulo 2^DW) unless COLLECTOR_SAT_EN is defined.
- Boundary conditions:
  - Gaps in in_valid are allowed; counters only move on accepted beats.
  - wr_ready may be tied high, giving one row per cycle.

Optional Feature:
- Macro: COLLECTOR_SAT_EN
- Defined: each accumulation saturates per lane to [-2^(DW-1), 2^(DW-1)-1], and a sticky output port sat_flag (1 bit) is added.
  - sat_flag sets on any clamp.
  - sat_flag clears on reset and on the start that launches a new job.
- Undefined: wrap-around add; no sat_flag port.

Test Plan:
- Single pass, overwrite: num_passes=1, base_addr=0x010, rows r=0..15 with lane k = r*16+k, wr_ready=1.
  - Expect 16 writes at addr 0x010..0x01F with identical data, then a done pulse; busy low afterwards.
- Three-pass accumulate: all lanes =5, then 7, then -2 on each pass.
  - Expect every written lane =10; num_passes=0 behaves identically to 1.
- Backpressure: wr_ready toggles 1,0,0,1,... during DRAIN.
  - wr_addr/wr_data hold while stalled; exactly 16 writes; no row duplicated or skipped.
- Overflow, two passes of lane 0 = 0x7000:
  - Without macro, expect 0xE000.
  - With COLLECTOR_SAT_EN, expect 0x7FFF and sat_flag=1.
- Address wrap and ignored start: ADDR_W=10, base_addr=0x3F8.
  - Expect writes to 0x3F8..0x3FF then 0x000..0x007.
  - start pulsed during CAPTURE changes nothing.
- Reset mid-DRAIN: drive rst=0 after 5 writes.
  - Next cycle wr_valid=0, busy=0, done never pulses.
  - A fresh single-pass job then completes normally.

Source files
------------

// File: rtl/systolic_output_collector.sv
// Collects row-serial systolic array output into a local buffer, accumulates over passes,
// then drains it row-by-row to a BRAM write port. Optional COLLECTOR_SAT_EN adds saturation.
module systolic_output_collector #(
    parameter int unsigned DW        = 16,
    parameter int unsigned Dimension = 16,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              num_passes,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW*Dimension-1:0] output_out,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DW*Dimension-1:0] wr_data,
`ifdef COLLECTOR_SAT_EN
    output logic                    sat_flag,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned RW   = (Dimension > 1) ? $clog2(Dimension) : 1;
    localparam int unsigned RowW = DW * Dimension;
    localparam logic [RW-1:0] LastRow = RW'(Dimension - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [7:0]        pass_q, pass_d;
    logic [7:0]        passes_q, passes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [RowW-1:0]   wr_data_q, wr_data_d;
    logic [RowW-1:0]   row_buf [Dimension];
    logic [RowW-1:0]   acc_row;
    logic [DW-1:0]     old_lane, new_lane;
    logic              beat;

    assign in_ready = (state_q == StCapture);
    assign beat     = in_valid && in_ready;

`ifdef COLLECTOR_SAT_EN
    logic [DW:0] sum_ext;
    logic        clamp_any;
    logic        sat_q;

    always_comb begin
        acc_row   = '0;
        clamp_any = 1'b0;
        old_lane  = '0;
        new_lane  = '0;
        sum_ext   = '0;
        for (int k = 0; k < Dimension; k++) begin
            old_lane = row_buf[row_q][DW*k +: DW];
            new_lane = output_out[DW*k +: DW];
            sum_ext  = {old_lane[DW-1], old_lane} + {new_lane[DW-1], new_lane};
            if (pass_q == 8'd0) begin
                acc_row[DW*k +: DW] = new_lane;
            end else if (sum_ext[DW] != sum_ext[DW-1]) begin
                // Sign of the true sum is the carry-out bit; clamp toward it.
                acc_row[DW*k +: DW] = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}}
                                                  : {1'b0, {(DW-1){1'b1}}};
                clamp_any = 1'b1;
            end else begin
                acc_row[DW*k +: DW] = sum_ext[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            sat_q <= 1'b0;
        end else if (beat && clamp_any) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        acc_row  = '0;
        old_lane = '0;
        new_lane = '0;
        for (int k = 0; k < Dimension; k++) begin
            old_lane = row_buf[row_q][DW*k +: DW];
            new_lane = output_out[DW*k +: DW];
            acc_row[DW*k +: DW] = (pass_q == 8'd0) ? new_lane : old_lane + new_lane;
        end
    end
`endif

    // Buffer is never cleared: pass 0 always overwrites every row.
    always_ff @(posedge clk) begin
        if (rst && beat) begin
            row_buf[row_q] <= acc_row;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pass_d    = pass_q;
        passes_d  = passes_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    passes_d = (num_passes == 8'd0) ? 8'd1 : num_passes;
                    base_d   = base_addr;
                    row_d    = '0;
                    pass_d   = 8'd0;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (beat) begin
                    if (row_q == LastRow) begin
                        row_d = '0;
                        if (pass_q == passes_q - 8'd1) begin
                            pass_d    = 8'd0;
                            state_d   = StDrain;
                            wr_addr_d = base_q;
                            // Only matters when Dimension==1 and row 0 is written this cycle.
                            wr_data_d = (row_q == '0) ? acc_row : row_buf[0];
                        end else begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (wr_ready) begin
                    if (row_q == LastRow) begin
                        row_d   = '0;
                        state_d = StDone;
                    end else begin
                        row_d     = row_q + 1'b1;
                        wr_addr_d = base_q + ADDR_W'(row_d);
                        wr_data_d = row_buf[row_d];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            pass_q    <= 8'd0;
            passes_q  <= 8'd0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pass_q    <= pass_d;
            passes_q  <= passes_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_valid = (state_q == StDrain);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector; covers the COLLECTOR_SAT_EN build as well.
module tb_systolic_output_collector;

    localparam int DW   = 16;
    localparam int DIM  = 16;
    localparam int AW   = 10;
    localparam int RowW = DW * DIM;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      num_passes = 8'd0;
    logic [AW-1:0]   base_addr = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [RowW-1:0] output_out = '0;
    logic            wr_valid;
    logic            wr_ready = 1'b1;
    logic [AW-1:0]   wr_addr;
    logic [RowW-1:0] wr_data;
    logic            busy;
    logic            done;
`ifdef COLLECTOR_SAT_EN
    logic            sat_flag;
`endif

    int errors = 0;
    int checks = 0;

    logic [AW-1:0]   got_addr[$];
    logic [RowW-1:0] got_data[$];
    int              hold_viol;

    systolic_output_collector #(.DW(DW), .Dimension(DIM), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .output_out (output_out),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef COLLECTOR_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [RowW-1:0] mk_row(input int r);
        logic [RowW-1:0] v;
        for (int k = 0; k < DIM; k++) v[DW*k +: DW] = 16'(r * 16 + k);
        return v;
    endfunction

    function automatic logic [RowW-1:0] fill_row(input logic [DW-1:0] x);
        logic [RowW-1:0] v;
        for (int k = 0; k < DIM; k++) v[DW*k +: DW] = x;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] np, input logic [AW-1:0] ba);
        start = 1'b1;
        num_passes = np;
        base_addr = ba;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input logic [RowW-1:0] d);
        in_valid = 1'b1;
        output_out = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Runs DRAIN until done is seen; bp selects the 1,0,0 wr_ready pattern.
    task automatic run_drain(input bit bp, output bit timed_out);
        int cyc = 0;
        bit stalled = 0;
        logic [AW-1:0] pa = '0;
        logic [RowW-1:0] pd = '0;
        got_addr.delete();
        got_data.delete();
        hold_viol = 0;
        timed_out = 0;
        while (done !== 1'b1) begin
            if (cyc > 300) begin
                timed_out = 1;
                break;
            end
            wr_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (stalled && (wr_addr !== pa || wr_data !== pd)) hold_viol++;
            if (wr_valid && wr_ready) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
            end
            stalled = wr_valid && !wr_ready;
            pa = wr_addr;
            pd = wr_data;
            tick();
            cyc++;
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, wr_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {in_ready, wr_valid, busy, done});
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_wr: got addr %0h data %0h want 0", wr_addr, wr_data);
        end
        rst = 1'b1;
        tick();
        tick();
        // in_valid without start must leave the block idle
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got busy %b in_ready %b want 0 0", busy, in_ready);
        end
        in_valid = 1'b0;
`ifdef COLLECTOR_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: got %b want 0", sat_flag);
        end
`endif
    endtask

    task automatic test_single_pass();
        bit to;
        start_job(8'd1, 10'h010);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sp_capture: got busy %b in_ready %b want 1 1", busy, in_ready);
        end
        for (int r = 0; r < DIM; r++) send_row(mk_row(r));
        checks++;
        if (wr_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sp_latency: got wr_valid %b in_ready %b want 1 0", wr_valid, in_ready);
        end
        run_drain(0, to);
        checks++;
        if (to || got_addr.size() != DIM) begin
            errors++;
            $display("FAIL sp_count: got %0d writes timeout %0d want 16", got_addr.size(), to);
        end
        for (int i = 0; i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== 10'(16 + i) || got_data[i] !== mk_row(i)) begin
                errors++;
                $display("FAIL sp_row%0d: got %0h/%0h want %0h/%0h", i, got_addr[i],
                         got_data[i], 10'(16 + i), mk_row(i));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sp_end: got done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic test_accumulate();
        bit to;
        logic [RowW-1:0] ten;
        ten = fill_row(16'h000A);
        start_job(8'd3, 10'h040);
        for (int r = 0; r < DIM; r++) begin
            send_row(fill_row(16'd5));
            if (r % 5 == 0) tick();
        end
        for (int r = 0; r < DIM; r++) send_row(fill_row(16'd7));
        for (int r = 0; r < DIM; r++) begin
            send_row(fill_row(16'hFFFE));
            if (r == 3) begin
                tick();
                tick();
            end
        end
        run_drain(0, to);
        checks++;
        if (to || got_data.size() != DIM) begin
            errors++;
            $display("FAIL acc_count: got %0d writes timeout %0d want 16", got_data.size(), to);
        end
        for (int i = 0; i < got_data.size(); i += 5) begin
            checks++;
            if (got_data[i] !== ten || got_addr[i] !== 10'(64 + i)) begin
                errors++;
                $display("FAIL acc_row%0d: got %0h/%0h want %0h/%0h", i, got_addr[i],
                         got_data[i], 10'(64 + i), ten);
            end
        end
        tick();
        // num_passes=0 is a single pass
        start_job(8'd0, 10'h080);
        for (int r = 0; r < DIM; r++) send_row(ten);
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL np0_drain: got wr_valid %b want 1", wr_valid);
        end
        run_drain(0, to);
        checks++;
        if (to || got_data.size() != DIM || got_data[DIM-1] !== ten) begin
            errors++;
            $display("FAIL np0_data: got %0d writes last %0h want 16 of %0h",
                     got_data.size(), (got_data.size() > 0) ? got_data[got_data.size()-1] : '0,
                     ten);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit to;
        start_job(8'd1, 10'h100);
        for (int r = 0; r < DIM; r++) send_row(~mk_row(r));
        run_drain(1, to);
        checks++;
        if (to || got_addr.size() != DIM) begin
            errors++;
            $display("FAIL bp_count: got %0d writes timeout %0d want 16", got_addr.size(), to);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d changes while stalled want 0", hold_viol);
        end
        for (int i = 0; i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== 10'(256 + i) || got_data[i] !== ~mk_row(i)) begin
                errors++;
                $display("FAIL bp_row%0d: got %0h/%0h want %0h/%0h", i, got_addr[i],
                         got_data[i], 10'(256 + i), ~mk_row(i));
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        bit to;
        logic [RowW-1:0] r7;
        logic [DW-1:0] exp_lane;
`ifdef COLLECTOR_SAT_EN
        exp_lane = 16'h7FFF;
`else
        exp_lane = 16'hE000;
`endif
        r7 = '0;
        r7[DW-1:0] = 16'h7000;
        start_job(8'd2, 10'h200);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < DIM; r++) send_row(r7);
        run_drain(0, to);
        checks++;
        if (to || got_data.size() != DIM) begin
            errors++;
            $display("FAIL ov_count: got %0d writes timeout %0d want 16", got_data.size(), to);
        end
        for (int i = 0; i < got_data.size(); i += 15) begin
            checks++;
            if (got_data[i][DW-1:0] !== exp_lane || got_data[i][RowW-1:DW] !== '0) begin
                errors++;
                $display("FAIL ov_row%0d: got lane0 %0h want %0h", i, got_data[i][DW-1:0],
                         exp_lane);
            end
        end
`ifdef COLLECTOR_SAT_EN
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL ov_sat_flag: got %b want 1", sat_flag);
        end
`endif
        tick();
    endtask

    task automatic test_addr_wrap();
        bit to;
        start_job(8'd1, 10'h3F8);
`ifdef COLLECTOR_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear_on_start: got %b want 0", sat_flag);
        end
`endif
        for (int r = 0; r < DIM; r++) begin
            send_row(mk_row(r + 3));
            if (r == 6) begin
                start = 1'b1;
                num_passes = 8'd5;
                base_addr = 10'h000;
                tick();
                start = 1'b0;
                checks++;
                if (in_ready !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ign_start: got in_ready %b busy %b want 1 1", in_ready, busy);
                end
            end
        end
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL ign_passes: got wr_valid %b want 1", wr_valid);
        end
        run_drain(0, to);
        checks++;
        if (to || got_addr.size() != DIM) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes timeout %0d want 16", got_addr.size(), to);
        end
        for (int i = 0; i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== 10'(1016 + i) || got_data[i] !== mk_row(i + 3)) begin
                errors++;
                $display("FAIL wrap_row%0d: got %0h/%0h want %0h/%0h", i, got_addr[i],
                         got_data[i], 10'(1016 + i), mk_row(i + 3));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        int done_seen = 0;
        start_job(8'd1, 10'h020);
        for (int r = 0; r < DIM; r++) send_row(mk_row(r));
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 10'h025) begin
            errors++;
            $display("FAIL mid_pre: got wr_valid %b addr %0h want 1 25", wr_valid, wr_addr);
        end
        rst = 1'b0;
        wr_ready = 1'b0;
        tick();
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got wr_valid %b busy %b done %b want 0 0 0", wr_valid,
                     busy, done);
        end
        rst = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done || wr_valid) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL mid_quiet: got %0d done/write cycles want 0", done_seen);
        end
        start_job(8'd1, 10'h030);
        for (int r = 0; r < DIM; r++) send_row(fill_row(16'(r)));
        run_drain(0, to);
        checks++;
        if (to || got_addr.size() != DIM || got_addr[0] !== 10'h030
            || got_data[DIM-1] !== fill_row(16'd15)) begin
            errors++;
            $display("FAIL mid_fresh: got %0d writes timeout %0d want 16 from 030",
                     got_addr.size(), to);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_accumulate();
        test_backpressure();
        test_overflow();
        test_addr_wrap();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
